branch_controller: RTL and testbench
====================================

# branch_controller

Execute-stage branch resolution unit of the RV32IM pipeline. Compares the two register operands according to the branch `func3`. It combines the result with the `Branch`/`Jump` control bits from decode and tells the PC-select mux whether to redirect fetch. It also supplies the redirect target taken from the ALU result.

## Interface
Parameters: none.

Ports:
- `CLK` input 1 — single clock; all state updates on the rising edge.
- `RESET` input 1 — synchronous, active-high reset.
- `data1` input 32 — rs1 operand, signed two's complement.
- `data2` input 32 — rs2 operand, signed two's complement.
- `func3` input 3 — branch condition select (RV32I B-type `funct3`).
- `ALUresult` input 32 — target address computed by the ALU (PC+imm or rs1+imm).
- `Branch` input 1 — instruction is a conditional branch.
- `Jump` input 1 — instruction is JAL/JALR (unconditional).
- `TargetedAddress` output 32 — registered redirect address.
- `PCAddressController` output 1 — registered PC-select: 1 = load `TargetedAddress`, 0 = PC+4.

## Operation
- Condition `cond` by `func3`:
  - 000 BEQ: data1 == data2
  - 001 BNE: data1 != data2
  - 100 BLT: signed data1 < data2
  - 101 BGE: signed data1 >= data2
  - 110 BLTU: unsigned data1 < data2
  - 111 BGEU: unsigned data1 >= data2
  - 010, 011: cond = 0 (reserved encodings never branch).
- `take = Jump | (Branch & cond)`.
  - `Jump` dominates; `Branch` and `Jump` both high is treated as taken.
  - Neither asserted gives not taken, regardless of operands.
- Target = `{ALUresult[31:1], 1'b0}`. Bit 0 is always cleared, per the JALR rule; this is harmless for JAL and branches.
- Full 32-bit compare; no overflow cases, since comparisons use the proper signed/unsigned relation, not subtraction sign.
- All inputs are treated as valid every cycle; there is no handshake.

## Timing
- On each rising `CLK` with `RESET`=0: `PCAddressController` ← take, `TargetedAddress` ← target.
- Latency is 1 cycle from inputs to outputs. Outputs are stable for the whole following cycle.
- `TargetedAddress` updates every cycle, even when not taken. Consumers qualify it with `PCAddressController`.
- `RESET`=1 at a rising edge: both outputs become 0 on that edge, overriding any inputs.
  - The first post-reset edge with `RESET`=0 loads the current inputs normally.
  - A taken branch whose capture edge coincides with reset is dropped.
- No internal state beyond the two output registers.
- No X propagation: reserved `func3` values and unknown controls resolve as "not taken" only where defined above. The design is otherwise fully decoded.

## Structure
- Shared package `rv32_pkg`:
  - `funct3` branch encodings: `F3_BEQ`=000, `F3_BNE`=001, `F3_BLT`=100, `F3_BGE`=101, `F3_BLTU`=110, `F3_BGEU`=111.
  - `XLEN`=32.
- One natural sub-module, `branch_comparator`. It is purely combinational: `data1`, `data2`, `func3` → `cond`.
- The top level holds the take/target logic and the output registers.

## Test plan
- Reset: assert `RESET` for 2 cycles with `Jump`=1 and `ALUresult`=24 → both outputs 0. First edge after release → `PCAddressController`=1, `TargetedAddress`=24.
- Signed less-than, `Branch`=1, `Jump`=0, `data1`=12, `data2`=15, `ALUresult`=24:
  - `func3`=100 → 1 after one edge.
  - `func3`=101 → 0.
  - `func3`=110 → 1.
- Equality, `data1`=15, `data2`=15:
  - `func3`=000 → 1.
  - `func3`=001 → 0.
  - `func3`=010 → 0.
- Signed vs unsigned with negative operand, `data1`=−15, `data2`=15:
  - `func3`=101 → 0.
  - `func3`=100 → 1.
  - `func3`=111 → 1.
  - `func3`=110 → 0.
- Control gating: `Branch`=0, `Jump`=0, with a true condition → 0. Then `Jump`=1, `Branch`=0, `func3`=001, `data1`=`data2` → 1.
- Target masking and latency: `ALUresult`=0x00001235, `Jump`=1 → `TargetedAddress`=0x00001234 exactly one edge later. It must not change before that edge.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and branch funct3 encodings
package rv32_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;
endpackage

// File: rtl/branch_comparator.sv
// branch_comparator: combinational branch condition evaluation from funct3
module branch_comparator
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [2:0]      func3,
  output logic            cond
);
  logic eq, lt_s, lt_u;
  assign eq   = data1 == data2;
  assign lt_s = $signed(data1) < $signed(data2);
  assign lt_u = data1 < data2;
  // reserved encodings 010/011 fall through to never-taken
  always_comb begin
    cond = 1'b0;
    case (func3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_controller.sv
// branch_controller: execute-stage branch resolution with registered redirect outputs
module branch_controller
  import rv32_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] ALUresult,
  input  logic            Branch,
  input  logic            Jump,
  output logic [XLEN-1:0] TargetedAddress,
  output logic            PCAddressController
);
  logic cond;
  logic take_d, take_q;
  logic [XLEN-1:0] target_d, target_q;
  branch_comparator u_cmp (
    .data1 (data1),
    .data2 (data2),
    .func3 (func3),
    .cond  (cond)
  );
  assign take_d   = Jump | (Branch & cond);
  assign target_d = {ALUresult[XLEN-1:1], 1'b0};
  always_ff @(posedge CLK) begin
    if (RESET) begin
      take_q   <= 1'b0;
      target_q <= '0;
    end else begin
      take_q   <= take_d;
      target_q <= target_d;
    end
  end
  assign PCAddressController = take_q;
  assign TargetedAddress     = target_q;
endmodule

// File: tb/tb_branch_controller.sv
// tb_branch_controller: directed and randomized checks against a behavioural branch model
module tb_branch_controller;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] data1 = '0, data2 = '0, ALUresult = '0;
  logic [2:0]  func3 = '0;
  logic        Branch = 1'b0, Jump = 1'b0;
  logic [31:0] TargetedAddress;
  logic        PCAddressController;
  int          errors = 0, checks = 0;
  logic [31:0] exp_tgt = '0;

  branch_controller dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .data1               (data1),
    .data2               (data2),
    .func3               (func3),
    .ALUresult           (ALUresult),
    .Branch              (Branch),
    .Jump                (Jump),
    .TargetedAddress     (TargetedAddress),
    .PCAddressController (PCAddressController)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    case (f3)
      3'd0:    return ua == ub;
      3'd1:    return ua != ub;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic jp, input logic [31:0] alu);
    RESET = rst; func3 = f3; data1 = a; data2 = b; Branch = br; Jump = jp; ALUresult = alu;
  endtask

  task automatic directed(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic br, input logic jp, input logic [31:0] alu, input logic exp_take);
    drive(1'b0, f3, a, b, br, jp, alu);
    @(posedge CLK); #1;
    exp_tgt = {alu[31:1], 1'b0};
    check({tag, "_take"}, {31'b0, PCAddressController}, {31'b0, exp_take});
    check({tag, "_tgt"}, TargetedAddress, exp_tgt);
  endtask

  initial begin
    drive(1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd24);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_take", {31'b0, PCAddressController}, 32'd0);
    check("rst_tgt", TargetedAddress, 32'd0);
    directed("rst_release", 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd24, 1'b1);

    directed("blt_lt", 3'b100, 32'd12, 32'd15, 1'b1, 1'b0, 32'd24, 1'b1);
    directed("bge_lt", 3'b101, 32'd12, 32'd15, 1'b1, 1'b0, 32'd24, 1'b0);
    directed("bltu_lt", 3'b110, 32'd12, 32'd15, 1'b1, 1'b0, 32'd24, 1'b1);
    directed("beq_eq", 3'b000, 32'd15, 32'd15, 1'b1, 1'b0, 32'd24, 1'b1);
    directed("bne_eq", 3'b001, 32'd15, 32'd15, 1'b1, 1'b0, 32'd24, 1'b0);
    directed("rsv_eq", 3'b010, 32'd15, 32'd15, 1'b1, 1'b0, 32'd24, 1'b0);
    directed("rsv3_eq", 3'b011, 32'd15, 32'd15, 1'b1, 1'b0, 32'd24, 1'b0);
    directed("bge_neg", 3'b101, -32'sd15, 32'd15, 1'b1, 1'b0, 32'd24, 1'b0);
    directed("blt_neg", 3'b100, -32'sd15, 32'd15, 1'b1, 1'b0, 32'd24, 1'b1);
    directed("bgeu_neg", 3'b111, -32'sd15, 32'd15, 1'b1, 1'b0, 32'd24, 1'b1);
    directed("bltu_neg", 3'b110, -32'sd15, 32'd15, 1'b1, 1'b0, 32'd24, 1'b0);
    directed("blt_min", 3'b100, 32'h8000_0000, 32'h7fff_ffff, 1'b1, 1'b0, 32'd24, 1'b1);
    directed("gate_off", 3'b000, 32'd15, 32'd15, 1'b0, 1'b0, 32'd24, 1'b0);
    directed("jump_dom", 3'b001, 32'd7, 32'd7, 1'b0, 1'b1, 32'd24, 1'b1);
    directed("both_hi", 3'b001, 32'd7, 32'd7, 1'b1, 1'b1, 32'd24, 1'b1);

    // target must hold its old value until the capturing edge
    drive(1'b0, 3'b000, 32'd0, 32'd1, 1'b0, 1'b1, 32'h0000_1235);
    #1;
    check("lat_hold", TargetedAddress, exp_tgt);
    @(posedge CLK); #1;
    check("lat_tgt", TargetedAddress, 32'h0000_1234);
    check("lat_take", {31'b0, PCAddressController}, 32'd1);

    drive(1'b1, 3'b000, 32'd3, 32'd3, 1'b1, 1'b1, 32'hffff_ffff);
    @(posedge CLK); #1;
    check("rst_drop_take", {31'b0, PCAddressController}, 32'd0);
    check("rst_drop_tgt", TargetedAddress, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic rst, br, jp, t;
      logic [2:0] f3;
      logic [31:0] a, b, alu;
      rst = ($urandom_range(15) == 0);
      f3  = 3'($urandom_range(7));
      a   = $urandom;
      b   = ($urandom_range(3) == 0) ? a : $urandom;
      if ($urandom_range(3) == 0) b = -b;
      br  = 1'($urandom_range(1));
      jp  = ($urandom_range(3) == 0);
      alu = $urandom;
      drive(rst, f3, a, b, br, jp, alu);
      @(posedge CLK); #1;
      t = rst ? 1'b0 : (jp | (br & ref_cond(f3, a, b)));
      check("rnd_take", {31'b0, PCAddressController}, {31'b0, t});
      check("rnd_tgt", TargetedAddress, rst ? 32'd0 : (alu & ~32'd1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
